// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the Moore sequence detector.
// One shifter plus one holding word gives a gapless bit stream.
module seq_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             seq_out,
   output logic             seq_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shreg_adv;
   logic             accept;
   logic             at_last;

   assign in_ready = !hold_full_q && !reset;
   assign accept   = in_valid && in_ready;
   assign at_last  = (state_q == SHIFT) && (bit_cnt_q == LAST);

   // The vacated bit position is never presented, so fill with zero.
   assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d   = in_data;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt_q != LAST) begin
               shreg_d   = shreg_adv;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (accept) begin
                  hold_d      = in_data;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               shreg_d     = hold_q;
               hold_full_d = 1'b0;
               bit_cnt_d   = '0;
            end else if (accept) begin
               shreg_d   = in_data;
               bit_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
      end
   end

   assign seq_valid = (state_q == SHIFT);
   assign seq_out   = seq_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0])
                                : IDLE_BIT;
   assign word_done = at_last;
   assign busy      = seq_valid || hold_full_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer.
// MSB/LSB-first instances vs bit queues.
module tb_seq_serializer;

  localparam int W = 8;
  localparam bit IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         m_ready, m_out;
  logic         m_valid, m_done, m_busy;
  logic         l_ready, l_out;
  logic         l_valid, l_done, l_busy;

  int           checks = 0;
  int           errors = 0;
  int           acc_cnt = 0;
  int           done_cnt = 0;
  bit           exp_ready = 1'b0;
  bit           qm[$];
  bit           ql[$];
  logic [15:0]  tm, tl;

  always #5 clk = ~clk;

  seq_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b1),
    .IDLE_BIT(IDLE)
  ) dut_m (
    .clk(clk), .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(m_ready),
    .seq_out(m_out),
    .seq_valid(m_valid),
    .word_done(m_done),
    .busy(m_busy)
  );

  seq_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0),
    .IDLE_BIT(IDLE)
  ) dut_l (
    .clk(clk), .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(l_ready),
    .seq_out(l_out),
    .seq_valid(l_valid),
    .word_done(l_done),
    .busy(l_busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $error("FAIL timeout: wait expired");
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  task automatic check_outs();
    int s;
    s = qm.size();
    exp_ready = (s <= W);
    chk("m_valid", m_valid, (s > 0));
    chk("l_valid", l_valid, (s > 0));
    chk("m_out", m_out,
        ((s > 0) ? qm[0] : IDLE));
    chk("l_out", l_out,
        ((s > 0) ? ql[0] : IDLE));
    chk("m_ready", m_ready, (s <= W));
    chk("l_ready", l_ready, (s <= W));
    chk("m_busy", m_busy, (s > 0));
    chk("l_busy", l_busy, (s > 0));
    chk("m_done", m_done, ((s % W) == 1));
    chk("l_done", l_done, ((s % W) == 1));
    if (m_valid) tm = {tm[14:0], m_out};
    if (l_valid) tl = {tl[14:0], l_out};
    if (m_done) done_cnt++;
    if (s > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
  endtask

  task automatic cycle(
    input logic         v,
    input logic [W-1:0] d
  );
    in_valid = v;
    in_data  = d;
    if (v && exp_ready) begin
      acc_cnt++;
      for (int i = W - 1; i >= 0; i--)
        qm.push_back(d[i]);
      for (int i = 0; i < W; i++)
        ql.push_back(d[i]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, '0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("rst_out", m_out, IDLE);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_done", m_done, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_ready", m_ready, 1'b0);
    chk("rst_l_ready", l_ready, 1'b0);
    reset = 1'b0;
    #1;
    check_outs();

    tm = '0; tl = '0;
    cycle(1'b1, 8'hD6);
    idle(9);
    chk("t1_m_bits", tm[7:0], 8'hD6);
    chk("t1_l_bits", tl[7:0], 8'h6B);

    tm = '0; tl = '0;
    cycle(1'b1, 8'hB4);
    cycle(1'b1, 8'h2D);
    idle(17);
    chk("t2_m_bits", tm, 16'hB42D);
    chk("t2_l_bits", tl, 16'h2DB4);

    tm = '0; tl = '0;
    cycle(1'b1, 8'h00);
    idle(7);
    cycle(1'b1, 8'hFF);
    idle(9);
    chk("t3_m_bits", tm, 16'h00FF);
    chk("t3_l_bits", tl, 16'h00FF);

    tm = '0; tl = '0;
    cycle(1'b1, 8'h0B);
    idle(9);
    chk("t4_l_bits", tl[7:0], 8'hD0);
    chk("t4_m_bits", tm[7:0], 8'h0B);

    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'hAA);
    cycle(1'b0, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_m_out", m_out, IDLE);
    chk("t5_l_out", l_out, IDLE);
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_m_busy", m_busy, 1'b0);
    chk("t5_l_busy", l_busy, 1'b0);
    chk("t5_m_ready", m_ready, 1'b0);
    chk("t5_m_done", m_done, 1'b0);
    qm.delete();
    ql.delete();
    acc_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_rel_ready", m_ready, 1'b1);
    check_outs();
    tm = '0; tl = '0;
    idle(10);
    chk("t5_no_stale", tm, 16'h0000);

    acc_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0),
            W'($urandom));
      chk("t6_inflight",
          ((acc_cnt - done_cnt) <= 2), 1'b1);
    end
    idle(20);
    chk("t6_all_done", done_cnt, acc_cnt);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
